// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter: default sizes, buffer state
// and the round-robin pick helper. Optional overflow flag: ADDER_ARB_OVF_EN.
package adder_arb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W_DEF  = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] win;
    } pick_t;

    // Scans valid from ptr upward (mod n) and returns the first set index; sized for up to 8 requesters.
    function automatic pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        pick_t res;
        int    idx;
        res.found = 1'b0;
        res.win   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k < n) && !res.found && valid[idx[2:0]]) begin
                res.found = 1'b1;
                res.win   = idx[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/carry_look_ahead.sv
// Shared WIDTH-bit adder: {c_out, sum} = in_1 + in_2 + c_in, built from
// generate/propagate terms.
module carry_look_ahead #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    input  logic             c_in,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2
);

    logic [WIDTH-1:0] gen_s;
    logic [WIDTH-1:0] prop_s;
    logic [WIDTH:0]   carry_s;

    assign gen_s  = in_1 & in_2;
    assign prop_s = in_1 ^ in_2;

    // Carry chain from generate/propagate terms.
    always_comb begin
        carry_s    = {(WIDTH+1){1'b0}};
        carry_s[0] = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            carry_s[i+1] = gen_s[i] | (prop_s[i] & carry_s[i]);
        end
    end

    assign sum   = prop_s ^ carry_s[WIDTH-1:0];
    assign c_out = carry_s[WIDTH];

endmodule

// File: rtl/rr_arbiter_core.sv
// Round-robin grant logic with its rotating priority pointer.
module rr_arbiter_core
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             can_accept,
    output logic [N_REQ-1:0] req_ready,
    output logic [ID_W-1:0]  win_id,
    output logic             grant
);

    logic [ID_W-1:0] rr_ptr_r;
    logic [7:0]      valid_ext_s;
    pick_t           pick_s;

    // Find the first valid requester at or after the pointer.
    always_comb begin
        valid_ext_s              = 8'd0;
        valid_ext_s[N_REQ-1:0]   = req_valid;
        pick_s                   = rr_pick(valid_ext_s, 3'(rr_ptr_r), N_REQ);
    end

    // Grant only when the buffer can take a result; ready stays low during reset.
    always_comb begin
        grant     = pick_s.found & can_accept & ~rst;
        win_id    = pick_s.win[ID_W-1:0];
        req_ready = {N_REQ{1'b0}};
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Pointer moves just past the winner; N_REQ is a power of two so it wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (grant) begin
            rr_ptr_r <= win_id + ID_W'(1'b1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one carry_look_ahead adder among N_REQ requesters with a one-entry
// tagged response buffer. ADDER_ARB_OVF_EN adds a registered signed-overflow flag.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_in_1,
    input  logic [N_REQ*WIDTH-1:0] req_in_2,
    input  logic [N_REQ-1:0]       req_c_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_c_out,
    output logic [ID_W-1:0]        rsp_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                   rsp_ovf
`endif
);

    buf_state_t       state_r;
    logic             can_accept_s;
    logic             grant_s;
    logic [ID_W-1:0]  win_id_s;
    logic [WIDTH-1:0] add_a_s;
    logic [WIDTH-1:0] add_b_s;
    logic [WIDTH-1:0] add_sum_s;
    logic             add_cin_s;
    logic             add_cout_s;

    assign can_accept_s = (state_r == EMPTY) | rsp_ready;
    assign rsp_valid    = (state_r == FULL);

    rr_arbiter_core #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .can_accept (can_accept_s),
        .req_ready  (req_ready),
        .win_id     (win_id_s),
        .grant      (grant_s)
    );

    // Steer the winner's operands into the adder; idle inputs sit at zero.
    always_comb begin
        add_a_s   = {WIDTH{1'b0}};
        add_b_s   = {WIDTH{1'b0}};
        add_cin_s = 1'b0;
        if (grant_s) begin
            add_a_s   = req_in_1[int'(win_id_s)*WIDTH +: WIDTH];
            add_b_s   = req_in_2[int'(win_id_s)*WIDTH +: WIDTH];
            add_cin_s = req_c_in[win_id_s];
        end else begin
            add_a_s   = {WIDTH{1'b0}};
            add_b_s   = {WIDTH{1'b0}};
            add_cin_s = 1'b0;
        end
    end

    carry_look_ahead #(
        .WIDTH (WIDTH)
    ) u_adder (
        .sum   (add_sum_s),
        .c_out (add_cout_s),
        .c_in  (add_cin_s),
        .in_1  (add_a_s),
        .in_2  (add_b_s)
    );

    // Response buffer: a grant always refills, otherwise a consumed entry empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= EMPTY;
            rsp_sum   <= {WIDTH{1'b0}};
            rsp_c_out <= 1'b0;
            rsp_id    <= {ID_W{1'b0}};
        end else if (grant_s) begin
            state_r   <= FULL;
            rsp_sum   <= add_sum_s;
            rsp_c_out <= add_cout_s;
            rsp_id    <= win_id_s;
        end else if (rsp_ready) begin
            state_r   <= EMPTY;
            rsp_sum   <= rsp_sum;
            rsp_c_out <= rsp_c_out;
            rsp_id    <= rsp_id;
        end else begin
            state_r   <= state_r;
            rsp_sum   <= rsp_sum;
            rsp_c_out <= rsp_c_out;
            rsp_id    <= rsp_id;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    // Signed overflow: like-signed operands producing a sum of the other sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if (grant_s) begin
            rsp_ovf <= (add_a_s[WIDTH-1] == add_b_s[WIDTH-1]) &
                       (add_sum_s[WIDTH-1] != add_a_s[WIDTH-1]);
        end else begin
            rsp_ovf <= rsp_ovf;
        end
    end
`endif

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 32-bit `carry_look_ahead` adder between N_REQ independent requesters using round-robin arbitration.
- Each requester presents operands with a valid/ready handshake.
- The winning operands drive the shared adder. The result is registered into a one-entry response buffer, tagged with the requester index.
- Sits between client datapaths and the single adder instance. It is the only block allowed to drive the adder inputs.

Parameters:
- WIDTH, 32, operand/sum width; must match the adder instance.
- N_REQ, 4, number of requesters (power of two, 2..8).
- ID_W, 2, requester tag width; equals log2(N_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_in_1  input  N_REQ*WIDTH  flattened operand A; slice i belongs to requester i.
- req_in_2  input  N_REQ*WIDTH  flattened operand B.
- req_c_in  input  N_REQ  per-requester carry-in.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_sum  output  WIDTH  registered sum.
- rsp_c_out  output  1  registered carry-out.
- rsp_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (asynchronous, immediate): rsp_valid=0, rsp_sum=0, rsp_c_out=0, rsp_id=0, rr_ptr=0, state=EMPTY. req_ready is 0 while rst is high.
- State machine (response buffer):
  - EMPTY → FULL on a grant.
  - FULL → FULL on grant with rsp_ready=1 (drain and refill in the same cycle).
  - FULL → EMPTY on rsp_ready=1 with no grant.
  - FULL holds while rsp_ready=0.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant rule (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo N_REQ.
  - The first valid requester wins.
  - req_ready[win]=can_accept; all other bits are 0.
- Pointer: on each grant, rr_ptr <= win+1 (mod N_REQ). rr_ptr is unchanged when there is no grant.
- Datapath:
  - The adder inputs are muxed from the winner's slice. With no winner they are driven to 0.
  - On grant, rsp_sum/rsp_c_out/rsp_id are loaded at the clock edge.
  - Latency is exactly 1 cycle from handshake to rsp_valid.
  - Throughput is 1 result/cycle when rsp_ready stays high.
- Arithmetic: unsigned modulo 2^WIDTH, {c_out,sum} = in_1 + in_2 + c_in. Signed interpretation is the consumer's concern.
- Requester rules:
  - Operands and c_in must stay stable while valid=1 and ready=0.
  - Deasserting valid before ready is allowed; the request is simply dropped.
- Backpressure: while FULL and rsp_ready=0, all req_ready=0 and the rsp_* outputs are held stable.
- Boundary conditions:
  - All requesters valid → strict rotation 0,1,2,3,0,…
  - A single requester continuously valid → granted every cycle.
  - rr_ptr wraps from N_REQ-1 to 0.
  - Reset during FULL discards the held result with no response emitted.

Optional Feature:
- Macro ADDER_ARB_OVF_EN.
  - Defined: adds output port rsp_ovf (1 bit), registered with the result, = signed two's-complement overflow: (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]). Reset value 0.
  - Undefined: the port does not exist and no overflow logic is generated.

Decomposition:
- Package adder_arb_pkg:
  - WIDTH/N_REQ/ID_W defaults.
  - Buffer state enum {EMPTY, FULL}.
  - Function rr_pick(valid, ptr) returning win index and found flag.
- One sub-module: rr_arbiter_core. It contains the pointer register plus combinational grant logic (req_valid, can_accept in; req_ready, win_id, grant out).
- The top level instantiates rr_arbiter_core, the existing carry_look_ahead (port order sum, c_out, c_in, in_1, in_2), and the response register/FSM.

Test Plan:
1. Only req0 valid, in_1=546546, in_2=123564, c_in=0, rsp_ready=1 → req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_sum=670110, rsp_c_out=0, rsp_id=0.
2. All four valid continuously, rsp_ready=1, distinct operands → rsp_id sequence 0,1,2,3,0 on consecutive cycles, each sum correct.
3. Result held, rsp_ready=0 for 3 cycles with req1 valid → req_ready=0000, rsp_* unchanged for 3 cycles; on the ready cycle req1 is granted and the new result appears on the next cycle.
4. req2 in_1=0xFFFFFFFF, in_2=0, c_in=1 → rsp_sum=0x00000000, rsp_c_out=1. Then in_1=0x7FFFFFFF, in_2=1, c_in=0 → sum 0x80000000, c_out=0, rsp_ovf=1 (with ADDER_ARB_OVF_EN).
5. rst pulsed asynchronously mid-cycle while FULL → rsp_valid falls before the next edge; after release, req3 and req0 both valid → req0 granted first (rr_ptr=0).
6. req0 and req2 continuously valid, rsp_ready=1 → grants alternate 0,2,0,2; neither requester starves.
